// File: rtl/jk_reg_bank.sv
// jk_reg_bank: bank of WIDTH flip-flops, JK/D/T/SR mode, saturating change counter.
// Ports: clk, rst_n (async low), en, sclr, mode[1:0], j/k[WIDTH], q/qbar[WIDTH],
//        chg_cnt[CNT_W], sr_err (only when JKREG_SR_ERR_EN is defined).
module jk_reg_bank #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sclr,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [CNT_W-1:0] chg_cnt
`ifdef JKREG_SR_ERR_EN
    ,
    output logic             sr_err
`endif
);

    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_qbar;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_next_q;
    logic [WIDTH-1:0] w_diff;
    logic [PC_W-1:0]  w_pc;
    logic [SUM_W-1:0] w_sum;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_comb begin
        w_next_q = r_q;
        unique case (mode)
            2'b00: w_next_q = (j & ~r_q) | (~k & r_q);
            2'b01: w_next_q = j;
            2'b10: w_next_q = r_q ^ j;
            2'b11: w_next_q = (j & ~k) | (r_q & ~(~j & k));
            default: w_next_q = r_q;
        endcase
    end

    assign w_diff = w_next_q ^ r_q;

    always_comb begin
        w_pc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pc = w_pc + PC_W'(w_diff[i]);
        end
    end

    // Widened sum so that even a full-width change cannot wrap a narrow counter.
    assign w_sum     = SUM_W'(r_cnt) + SUM_W'(w_pc);
    assign w_cnt_nxt = (w_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}}
                                                        : w_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            r_qbar <= '1;
            r_cnt  <= '0;
        end else if (sclr) begin
            r_q    <= '0;
            r_qbar <= '1;
            r_cnt  <= '0;
        end else if (en) begin
            r_q    <= w_next_q;
            r_qbar <= ~w_next_q;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign q       = r_q;
    assign qbar    = r_qbar;
    assign chg_cnt = r_cnt;

`ifdef JKREG_SR_ERR_EN
    logic r_sr_err;
    logic w_sr_bad;

    assign w_sr_bad = (mode == 2'b11) && (|(j & k));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr_err <= 1'b0;
        end else if (sclr) begin
            r_sr_err <= 1'b0;
        end else if (en && w_sr_bad) begin
            r_sr_err <= 1'b1;
        end
    end

    assign sr_err = r_sr_err;
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
// tb_jk_reg_bank: directed + random checks of jk_reg_bank (CNT_W=16 and CNT_W=4).
// Scoreboard queue of expected states, popped one cycle after each drive.
module tb_jk_reg_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, sclr;
    logic [1:0] mode;
    logic [7:0] j, k;
    logic [7:0] q, qbar, q4, qbar4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
`ifdef JKREG_SR_ERR_EN
    logic sr_err, sr_err4;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  q;
        logic [7:0]  qb;
        logic [15:0] c16;
        logic [3:0]  c4;
        logic        err;
    } exp_t;

    exp_t sb[$];

    logic [7:0]  m_q;
    logic [15:0] m_c16;
    logic [3:0]  m_c4;
    logic        m_err;

    always #5 clk = ~clk;

    jk_reg_bank #(.WIDTH(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sclr(sclr), .mode(mode),
        .j(j), .k(k), .q(q), .qbar(qbar), .chg_cnt(cnt)
`ifdef JKREG_SR_ERR_EN
        , .sr_err(sr_err)
`endif
    );

    jk_reg_bank #(.WIDTH(8), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .sclr(sclr), .mode(mode),
        .j(j), .k(k), .q(q4), .qbar(qbar4), .chg_cnt(cnt4)
`ifdef JKREG_SR_ERR_EN
        , .sr_err(sr_err4)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q = 8'h00; m_c16 = 16'd0; m_c4 = 4'd0; m_err = 1'b0;
    endtask

    task automatic push_model();
        exp_t e;
        e.q = m_q; e.qb = ~m_q; e.c16 = m_c16; e.c4 = m_c4; e.err = m_err;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_q"}, 32'(q), 32'(e.q));
        chk({tag, "_qbar"}, 32'(qbar), 32'(e.qb));
        chk({tag, "_cnt"}, 32'(cnt), 32'(e.c16));
        chk({tag, "_q4"}, 32'(q4), 32'(e.q));
        chk({tag, "_qbar4"}, 32'(qbar4), 32'(e.qb));
        chk({tag, "_cnt4"}, 32'(cnt4), 32'(e.c4));
`ifdef JKREG_SR_ERR_EN
        chk({tag, "_err"}, 32'(sr_err), 32'(e.err));
        chk({tag, "_err4"}, 32'(sr_err4), 32'(e.err));
`endif
    endtask

    task automatic step(input string tag, input logic e_, input logic s_,
                        input logic [1:0] m_, input logic [7:0] jj,
                        input logic [7:0] kk);
        logic [7:0] nq;
        int pc;
        en = e_; sclr = s_; mode = m_; j = jj; k = kk;
        if (s_) begin
            model_reset();
        end else if (e_) begin
            for (int i = 0; i < 8; i++) begin
                nq[i] = m_q[i];
                case (m_)
                    2'b00: case ({jj[i], kk[i]})
                               2'b01: nq[i] = 1'b0;
                               2'b10: nq[i] = 1'b1;
                               2'b11: nq[i] = ~m_q[i];
                               default: nq[i] = m_q[i];
                           endcase
                    2'b01: nq[i] = jj[i];
                    2'b10: if (jj[i]) nq[i] = ~m_q[i];
                    default: begin
                        if (jj[i] && !kk[i]) nq[i] = 1'b1;
                        if (!jj[i] && kk[i]) nq[i] = 1'b0;
                        if (jj[i] && kk[i]) m_err = 1'b1;
                    end
                endcase
            end
            pc = $countones(nq ^ m_q);
            m_c16 = (int'(m_c16) + pc > 65535) ? 16'hFFFF : m_c16 + 16'(pc);
            m_c4  = (int'(m_c4) + pc > 15) ? 4'hF : m_c4 + 4'(pc);
            m_q = nq;
        end
        push_model();
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; sclr = 1'b0; mode = 2'b00; j = '0; k = '0;
        model_reset();
        #12;
        push_model();
        pop_check("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step("jk_set",    1, 0, 2'b00, 8'hFF, 8'h00);
        step("jk_tgl1",   1, 0, 2'b00, 8'h0F, 8'h0F);
        step("jk_tgl2",   1, 0, 2'b00, 8'h0F, 8'h0F);
        step("jk_clr",    1, 0, 2'b00, 8'h00, 8'hF0);
        step("jk_hold",   1, 0, 2'b00, 8'h00, 8'h00);
        step("d_en0",     0, 0, 2'b01, 8'hA5, 8'h00);
        step("d_load",    1, 0, 2'b01, 8'hA5, 8'h3C);
        step("sclr_en0",  0, 1, 2'b01, 8'hA5, 8'h00);
        step("t_1",       1, 0, 2'b10, 8'hFF, 8'hFF);
        step("t_2",       1, 0, 2'b10, 8'hFF, 8'h00);
        step("t_3",       1, 0, 2'b10, 8'hFF, 8'h00);
        step("t_hold",    1, 0, 2'b10, 8'h00, 8'hFF);
        step("sr_set",    1, 0, 2'b11, 8'h0F, 8'hF0);
        step("sr_clr",    1, 0, 2'b11, 8'h03, 8'h0C);
        step("sr_ill",    1, 0, 2'b11, 8'h01, 8'h01);
        step("sr_idle",   1, 0, 2'b11, 8'h00, 8'h00);
        step("en0_mode",  0, 0, 2'b01, 8'h55, 8'hAA);
        step("sr_sclr",   1, 1, 2'b11, 8'hFF, 8'h00);
        step("sclr_pri",  1, 1, 2'b01, 8'hFF, 8'h00);
        step("load_3c",   1, 0, 2'b01, 8'h3C, 8'h00);

        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        push_model();
        pop_check("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("resume",    1, 0, 2'b00, 8'hFF, 8'h00);

        for (int n = 0; n < 40; n++) begin
            step("rand", 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 15) == 0), 2'($urandom),
                 8'($urandom), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
